sound_detect: RTL and testbench
===============================

Name: sound_detect

Overview:
- Upstream conditioning stage for the intrusion FSM: turns the raw digital microphone comparator output into the qualified `sound_data` level that the FSM samples while waiting for sound.
- Counts rising edges of the synchronised mic signal in fixed windows.
- Asserts `sound_data` only after several consecutive loud windows, and releases it after several consecutive quiet windows.

Parameters:
- WINDOW_CYCLES, 50000: clocks per measurement window (>=2).
- CNT_W, 16: width of the edge counter and `sound_level`. The counter saturates at 2^CNT_W-1.
- EDGE_THRESH, 8: a window is a "hit" when its edge count is >= EDGE_THRESH.
- HIT_WINDOWS, 3: consecutive hit windows needed to assert. 0 is treated as 1.
- HOLD_WINDOWS, 4: consecutive miss windows needed to release. 0 is treated as 1.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (asserted when 0).
- enable, input, 1: detector run enable.
- sound_raw, input, 1: asynchronous mic comparator output.
- sound_clear, input, 1: synchronous clear pulse. Used only with SOUND_STICKY_EN.
- sound_data, output, 1: qualified sound present (registered).
- sound_level, output, CNT_W: edge count of the last completed window.
- window_tick, output, 1: one-clock pulse on the last cycle of each window.

Behaviour:
- Reset (reset=0): all outputs 0, all counters 0, FSM in IDLE, synchroniser flops 0. Takes effect immediately, regardless of clk.
- Input path:
  - 2-flop synchroniser plus one delay flop.
  - edge = s1 & ~s2.
  - Latency from a sound_raw rise to the edge being counted is 3 clocks.
- Window counter:
  - Counts 0..WINDOW_CYCLES-1, then wraps to 0.
  - window_tick = 1 while the counter equals WINDOW_CYCLES-1.
- Edge counter:
  - Increments on edge and saturates at 2^CNT_W-1.
  - An edge on the window_tick cycle belongs to the closing window.
  - On window_tick: sound_level <= final count, the edge counter clears to 0, and hit = (final count >= EDGE_THRESH).
- enable=0:
  - Window and edge counters held at 0; window_tick=0.
  - FSM forced to IDLE; sound_data=0; sound_level cleared to 0.
  - Enable has priority over a simultaneous tick.
  - When enable returns to 1, a fresh window starts at count 0.
- FSM advances only on window_tick:
  - IDLE:
    - hit -> QUALIFY with hit_cnt=1.
    - If HIT_WINDOWS<=1, hit -> ACTIVE directly.
    - miss -> stay.
  - QUALIFY:
    - hit -> hit_cnt+1; when hit_cnt+1 == HIT_WINDOWS -> ACTIVE.
    - miss -> IDLE, hit_cnt=0.
  - ACTIVE:
    - hit -> stay.
    - miss -> HOLD with miss_cnt=1.
    - If HOLD_WINDOWS<=1, miss -> IDLE.
  - HOLD:
    - hit -> ACTIVE, miss_cnt=0.
    - miss -> miss_cnt+1; when miss_cnt+1 == HOLD_WINDOWS -> IDLE.
- sound_data:
  - sound_data = 1 iff the state is ACTIVE or HOLD.
  - Rises and falls exactly 1 clock after the deciding window_tick.
  - HOLD never drops sound_data, so there are no glitches on a hit/miss alternation.
- Internal counters: hit_cnt and miss_cnt are sized to hold their parameter values and never wrap.

Optional Feature:
- Macro: SOUND_STICKY_EN.
- Defined:
  - ACTIVE ignores misses (no HOLD entry); sound_data stays 1 until sound_clear=1, enable=0, or reset.
  - sound_clear=1 -> next clock: FSM IDLE, sound_data 0, hit/miss counters 0, window and edge counters restart at 0.
  - sound_clear has priority over a same-cycle window_tick.
  - sound_clear in IDLE or QUALIFY also restarts the window and returns to IDLE.
- Not defined: sound_clear ignored; release follows the HOLD_WINDOWS rule.

Test Plan:
Bench parameters: WINDOW_CYCLES=16, CNT_W=4, EDGE_THRESH=3, HIT_WINDOWS=3, HOLD_WINDOWS=2.
- Reset: drive a tone until sound_data=1, then pull reset=0 between clock edges -> sound_data, sound_level and window_tick are 0 immediately. After release, the first window_tick comes 16 clocks after the first enabled clock.
- Qualify: continuous square wave with period 4 clk -> sound_level=4 at every tick. sound_data rises 1 clk after the 3rd full-window tick, and is 0 before that.
- Sub-threshold and broken runs:
  - Period 8 clk (2 edges per window) -> sound_level=2 and sound_data never rises.
  - Window pattern hit,hit,miss,hit,hit -> sound_data stays 0.
- Release and HOLD:
  - From ACTIVE, stop the tone -> sound_data still 1 after the 1st miss tick, and falls 1 clk after the 2nd miss tick.
  - Pattern miss,hit -> sound_data never drops.
- Saturation and edge-on-tick: with CNT_W=2, 6 edges in one window -> sound_level=3. An edge synchronised on the tick cycle is counted in the closing window, and the next window starts at 0.
- Sticky and enable:
  - With SOUND_STICKY_EN: after assertion, 5 silent windows -> sound_data stays 1. A sound_clear pulse -> 0 next clock. A sound_clear coinciding with a hit tick still gives IDLE.
  - Without the macro: sound_clear has no effect.
  - enable=0 for 1 clk while ACTIVE -> sound_data=0 next clock, and requalification takes 3 full windows.

Source files
------------

// File: rtl/sound_detect.sv
// sound_detect: qualifies a raw mic comparator output into a windowed, debounced sound_data level.
// Optional macro SOUND_STICKY_EN: sound_data latches once asserted and is released only by sound_clear.
`timescale 1ns/1ps
module sound_detect #(
  parameter int unsigned WINDOW_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned EDGE_THRESH   = 8,
  parameter int unsigned HIT_WINDOWS   = 3,
  parameter int unsigned HOLD_WINDOWS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sound_raw,
  input  logic             sound_clear,
  output logic             sound_data,
  output logic [CNT_W-1:0] sound_level,
  output logic             window_tick
);
  localparam int unsigned HIT_N  = (HIT_WINDOWS == 0) ? 1 : HIT_WINDOWS;
  localparam int unsigned HOLD_N = (HOLD_WINDOWS == 0) ? 1 : HOLD_WINDOWS;
  localparam int unsigned WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned HIT_W  = $clog2(HIT_N + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_N + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUALIFY = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic              r_meta, r_s1, r_s2;
  logic [WIN_W-1:0]  r_win;
  logic [CNT_W-1:0]  r_edge, r_level;
  logic [1:0]        r_state;
  logic [HIT_W-1:0]  r_hit_cnt;
  logic [HOLD_W-1:0] r_miss_cnt;
  logic              r_data;

  logic              w_edge, w_tick, w_hit, w_clear, w_restart;
  logic [CNT_W-1:0]  w_final;
  logic [1:0]        w_state_nxt;
  logic [HIT_W-1:0]  w_hit_nxt;
  logic [HOLD_W-1:0] w_miss_nxt;

`ifdef SOUND_STICKY_EN
  assign w_clear = sound_clear;
`else
  logic w_unused_clear;
  assign w_unused_clear = sound_clear;
  assign w_clear        = 1'b0;
`endif

  assign w_edge    = r_s1 & ~r_s2;
  assign w_tick    = enable & (r_win == WIN_LAST);
  assign w_restart = ~enable | w_clear;
  // An edge landing on the tick cycle is folded into the closing window's count.
  assign w_final   = (w_edge && (r_edge != CNT_MAX)) ? r_edge + 1'b1 : r_edge;
  assign w_hit     = 32'(w_final) >= EDGE_THRESH;

  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = r_hit_cnt;
    w_miss_nxt  = r_miss_cnt;
    if (w_restart) begin
      w_state_nxt = S_IDLE;
      w_hit_nxt   = '0;
      w_miss_nxt  = '0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            if (HIT_N <= 1) begin
              w_state_nxt = S_ACTIVE;
            end else begin
              w_state_nxt = S_QUALIFY;
              w_hit_nxt   = HIT_W'(1);
            end
          end
        end
        S_QUALIFY: begin
          if (!w_hit) begin
            w_state_nxt = S_IDLE;
            w_hit_nxt   = '0;
          end else if (32'(r_hit_cnt) + 1 == HIT_N) begin
            w_state_nxt = S_ACTIVE;
            w_hit_nxt   = '0;
          end else begin
            w_hit_nxt = r_hit_cnt + 1'b1;
          end
        end
        S_ACTIVE: begin
`ifndef SOUND_STICKY_EN
          if (!w_hit) begin
            if (HOLD_N <= 1) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_HOLD;
              w_miss_nxt  = HOLD_W'(1);
            end
          end
`endif
        end
        default: begin
          if (w_hit) begin
            w_state_nxt = S_ACTIVE;
            w_miss_nxt  = '0;
          end else if (32'(r_miss_cnt) + 1 == HOLD_N) begin
            w_state_nxt = S_IDLE;
            w_miss_nxt  = '0;
          end else begin
            w_miss_nxt = r_miss_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta     <= 1'b0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_win      <= '0;
      r_edge     <= '0;
      r_level    <= '0;
      r_state    <= S_IDLE;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_data     <= 1'b0;
    end else begin
      r_meta <= sound_raw;
      r_s1   <= r_meta;
      r_s2   <= r_s1;
      if (w_restart || w_tick) begin
        r_win  <= '0;
        r_edge <= '0;
      end else begin
        r_win  <= r_win + 1'b1;
        r_edge <= w_final;
      end
      if (!enable) begin
        r_level <= '0;
      end else if (w_tick && !w_clear) begin
        r_level <= w_final;
      end
      r_state    <= w_state_nxt;
      r_hit_cnt  <= w_hit_nxt;
      r_miss_cnt <= w_miss_nxt;
      r_data     <= (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_HOLD);
    end
  end

  assign sound_data  = r_data;
  assign sound_level = r_level;
  assign window_tick = w_tick;

endmodule

// File: tb/tb_sound_detect.sv
// Directed bench for sound_detect: 16-cycle windows, threshold 3, 3 hit windows, 2 hold windows.
`timescale 1ns/1ps
module tb_sound_detect;
`ifdef SOUND_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam logic [15:0] SIL   = 16'h0000;
  localparam logic [15:0] TONE4 = 16'h3333;
  localparam logic [15:0] TONE8 = 16'h0F0F;

  logic       clk = 1'b0;
  logic       reset, enable, sound_raw, sound_clear;
  logic       sound_data, window_tick, data2, tick2;
  logic [3:0] sound_level;
  logic [1:0] level2;
  logic       pre_data;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  sound_detect #(.WINDOW_CYCLES(16), .CNT_W(4), .EDGE_THRESH(3), .HIT_WINDOWS(3), .HOLD_WINDOWS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sound_raw(sound_raw), .sound_clear(sound_clear),
    .sound_data(sound_data), .sound_level(sound_level), .window_tick(window_tick)
  );

  sound_detect #(.WINDOW_CYCLES(16), .CNT_W(2), .EDGE_THRESH(3), .HIT_WINDOWS(3), .HOLD_WINDOWS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .sound_raw(sound_raw), .sound_clear(sound_clear),
    .sound_data(data2), .sound_level(level2), .window_tick(tick2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One aligned window: bit k of pat is the raw level during window cycle k.
  task automatic win(input logic [15:0] pat, input int clr_k);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0)  chk("tick_first", window_tick, 1'b0);
      if (k == 14) chk("tick_early", window_tick, 1'b0);
      if (k == 15) begin
        chk("tick_last", window_tick, 1'b1);
        pre_data = sound_data;
      end
      sound_raw   = pat[k];
      sound_clear = (k == clr_k);
    end
    @(posedge clk);
    #1;
    sound_clear = 1'b0;
  endtask

`ifdef SOUND_STICKY_EN
  task automatic clear_pulse();
    sound_clear = 1'b1;
    @(posedge clk);
    #1;
    sound_clear = 1'b0;
    chk("clear_data", sound_data, 1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enable = 1'b1; sound_raw = 1'b0; sound_clear = 1'b0; pre_data = 1'b0;
    #1;
    chk("rst_data", sound_data, 1'b0);
    chk("rst_level", sound_level, 4'd0);
    chk("rst_tick", window_tick, 1'b0);
    chk("rst_level2", level2, 2'd0);
    chk("rst_tick2", tick2, 1'b0);
    chk("rst_data2", data2, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // qualify: three hit windows
    win(TONE4, -1); chk("q1_level", sound_level, 4'd4); chk("q1_data", sound_data, 1'b0);
    chk("q1_level2", level2, 2'd3);
    win(TONE4, -1); chk("q2_level", sound_level, 4'd4); chk("q2_data", sound_data, 1'b0);
    win(TONE4, -1); chk("q3_pre", pre_data, 1'b0);
    chk("q3_level", sound_level, 4'd4); chk("q3_data", sound_data, 1'b1);
    win(TONE4, -1); chk("act_data", sound_data, 1'b1);

    // release through HOLD
    win(SIL, -1); chk("rel1_level", sound_level, 4'd0); chk("rel1_data", sound_data, 1'b1);
    win(SIL, -1); chk("rel2_pre", pre_data, 1'b1); chk("rel2_data", sound_data, STICKY);
`ifdef SOUND_STICKY_EN
    clear_pulse();
`endif

    // sub-threshold tone
    for (int i = 0; i < 3; i++) begin
      win(TONE8, -1); chk("sub_level", sound_level, 4'd2); chk("sub_data", sound_data, 1'b0);
      chk("sub_level2", level2, 2'd2);
    end

    // broken run hit,hit,miss,hit,hit
    win(TONE4, -1); chk("brk1_data", sound_data, 1'b0);
    win(TONE4, -1); chk("brk2_data", sound_data, 1'b0);
    win(SIL, -1);   chk("brk3_data", sound_data, 1'b0); chk("brk3_level", sound_level, 4'd0);
    win(TONE4, -1); chk("brk4_data", sound_data, 1'b0);
    win(TONE4, -1); chk("brk5_data", sound_data, 1'b0);
    win(TONE4, -1); chk("brk6_data", sound_data, 1'b1);

    // miss,hit alternation holds sound_data
    for (int i = 0; i < 2; i++) begin
      win(SIL, -1);   chk("alt_miss_data", sound_data, 1'b1);
      win(TONE4, -1); chk("alt_hit_data", sound_data, 1'b1);
    end

    // edge on the tick cycle closes into the current window
    win(16'h2022, -1); chk("tickedge_level", sound_level, 4'd3); chk("tickedge_level2", level2, 2'd3);
    win(SIL, -1);      chk("after_tick_level", sound_level, 4'd0); chk("after_tick_data", sound_data, 1'b1);

    // six edges: saturates the 2-bit counter
    win(16'h0555, -1); chk("sat_level", sound_level, 4'd6); chk("sat_level2", level2, 2'd3);
    chk("sat_data", sound_data, 1'b1);

`ifdef SOUND_STICKY_EN
    for (int i = 0; i < 5; i++) begin
      win(SIL, -1); chk("sticky_data", sound_data, 1'b1);
    end
    clear_pulse();
    win(TONE4, -1); chk("sq1_data", sound_data, 1'b0);
    win(TONE4, -1); chk("sq2_data", sound_data, 1'b0);
    win(TONE4, 15); chk("sq_clrtick_data", sound_data, 1'b0);
    win(TONE4, -1); chk("sq4_data", sound_data, 1'b0);
    win(TONE4, -1); chk("sq5_data", sound_data, 1'b0);
    win(TONE4, -1); chk("sq6_data", sound_data, 1'b1);
`else
    win(TONE4, 7); chk("noclr_data", sound_data, 1'b1); chk("noclr_level", sound_level, 4'd4);
`endif

    // one-cycle enable drop while active
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("en_data", sound_data, 1'b0);
    chk("en_level", sound_level, 4'd0);
    chk("en_tick", window_tick, 1'b0);
    chk("en_level2", level2, 2'd0);
    enable = 1'b1;
    win(TONE4, -1); chk("en_q1_data", sound_data, 1'b0);
    win(TONE4, -1); chk("en_q2_data", sound_data, 1'b0);
    win(TONE4, -1); chk("en_q3_data", sound_data, 1'b1); chk("en_q3_level", sound_level, 4'd4);

    // asynchronous reset mid-cycle
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_data", sound_data, 1'b0);
    chk("arst_level", sound_level, 4'd0);
    chk("arst_tick", window_tick, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    win(TONE4, -1); chk("post_rst_level", sound_level, 4'd4); chk("post_rst_data", sound_data, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
